// File: rtl/aes_dec_pkg.sv
`default_nettype none
// ============================================================================
// aes_dec_pkg : stage-op and FSM encodings shared by the AES decrypt sequencer
// Revision    : 1.0
// ============================================================================
package aes_dec_pkg;

  localparam int NR_DEFAULT = 10;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_SHIFT = 2'd2;
  localparam logic [1:0] OP_MIX   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIN   = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/aes_dec_step_decode.sv
`default_nettype none
// ============================================================================
// aes_dec_step_decode : maps a sequencer step number to stage op and round key
// Revision            : 1.0
// ============================================================================
module aes_dec_step_decode
  import aes_dec_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic [5:0] step_i,
  output logic [1:0] op_o,
  output logic [3:0] round_o
);

  localparam logic [3:0] FIRST_ROUND = 4'(NR);
  localparam logic [3:0] LAST_ROUND  = 4'(NR - 1);

  logic [5:0] k;

  // After the initial AddRoundKey every round runs Shift,Sub,Add,Mix; the
  // final round is the same pattern truncated before Mix, so one rule covers it.
  always_comb begin
    k       = step_i - 6'd1;
    op_o    = OP_ADD;
    round_o = FIRST_ROUND;
    if (step_i != 6'd0) begin
      round_o = LAST_ROUND - k[5:2];
      case (k[1:0])
        2'd0:    op_o = OP_SHIFT;
        2'd1:    op_o = OP_SUB;
        2'd2:    op_o = OP_ADD;
        default: op_o = OP_MIX;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_dec_round_sequencer.sv
`default_nettype none
// ============================================================================
// aes_dec_round_sequencer : steps the AES inverse cipher through its stages
// Revision                : 1.0
// ============================================================================
module aes_dec_round_sequencer
  import aes_dec_pkg::*;
#(
  parameter int NR      = NR_DEFAULT,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Start_i,
  input  logic [127:0] CipherText_i,
  output logic         Busy_o,
  output logic         Done_o,
  output logic         Error_o,
  output logic [127:0] PlainText_o,
  output logic [3:0]   RoundIdx_o,
  output logic [127:0] StageText_o,
  output logic         AddGo_o,
  output logic         SubGo_o,
  output logic         ShiftGo_o,
  output logic         MixGo_o,
  input  logic         Ry_i,
  input  logic [127:0] Text_i
);

  localparam logic [5:0] LAST_STEP   = 6'(4 * NR - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_e       state_q, state_d;
  logic [5:0]   step_q,  step_d;
  logic [7:0]   cnt_q,   cnt_d;
  logic [127:0] stage_q, stage_d;
  logic [127:0] plain_q, plain_d;
  logic         busy_q,  busy_d;
  logic         err_q,   err_d;
  logic         done_q,  done_d;

  logic [1:0]   dec_op;
  logic [3:0]   dec_round;

  aes_dec_step_decode #(.NR(NR)) u_step_decode (
    .step_i  (step_q),
    .op_o    (dec_op),
    .round_o (dec_round)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 6'd0;
      cnt_q   <= 8'd0;
      stage_q <= 128'd0;
      plain_q <= 128'd0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      plain_q <= plain_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    plain_d    = plain_q;
    busy_d     = busy_q;
    err_d      = err_q;
    done_d     = 1'b0;
    AddGo_o    = 1'b0;
    SubGo_o    = 1'b0;
    ShiftGo_o  = 1'b0;
    MixGo_o    = 1'b0;
    RoundIdx_o = 4'd0;

    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (Start_i) begin
          state_d = ST_ISSUE;
          stage_d = CipherText_i;
          step_d  = 6'd0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        RoundIdx_o = dec_round;
        cnt_d      = 8'd0;
        state_d    = ST_WAIT;
        case (dec_op)
          OP_ADD:   AddGo_o   = 1'b1;
          OP_SUB:   SubGo_o   = 1'b1;
          OP_SHIFT: ShiftGo_o = 1'b1;
          default:  MixGo_o   = 1'b1;
        endcase
      end
      ST_WAIT: begin
        RoundIdx_o = dec_round;
        // A result arriving on the final timeout cycle still counts.
        if (Ry_i) begin
          stage_d = Text_i;
          if (step_q == LAST_STEP) begin
            state_d = ST_FIN;
          end else begin
            step_d  = step_q + 6'd1;
            state_d = ST_ISSUE;
          end
        end else if (cnt_q == TIMEOUT_CNT) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_FIN: begin
        plain_d = stage_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy_o      = busy_q;
  assign Done_o      = done_q;
  assign Error_o     = err_q;
  assign PlainText_o = plain_q;
  assign StageText_o = stage_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_round_sequencer.sv
`default_nettype none
// ============================================================================
// tb_aes_dec_round_sequencer : AES stage models + vector table for the sequencer
// Revision                   : 1.0
// ============================================================================
module tb_aes_dec_round_sequencer;

  localparam int NR      = 10;
  localparam int TIMEOUT = 255;
  localparam logic [127:0] KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [3:0] G_ADD = 4'b0001, G_SUB = 4'b0010, G_SHIFT = 4'b0100, G_MIX = 4'b1000;
  localparam int NVEC = 6;

  logic         clk, rst, Start, Busy, Done, Error, Ry;
  logic         AddGo, SubGo, ShiftGo, MixGo;
  logic [127:0] CipherText, PlainText, StageText, Text;
  logic [3:0]   RoundIdx;
  logic [3:0]   go;

  assign go = {MixGo, ShiftGo, SubGo, AddGo};

  aes_dec_round_sequencer #(.NR(NR), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .Start_i      (Start),
    .CipherText_i (CipherText),
    .Busy_o       (Busy),
    .Done_o       (Done),
    .Error_o      (Error),
    .PlainText_o  (PlainText),
    .RoundIdx_o   (RoundIdx),
    .StageText_o  (StageText),
    .AddGo_o      (AddGo),
    .SubGo_o      (SubGo),
    .ShiftGo_o    (ShiftGo),
    .MixGo_o      (MixGo),
    .Ry_i         (Ry),
    .Text_i       (Text)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  logic [7:0]   sbox [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk [NR+1];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] getb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? inv_sbox[getb(s, i)] : sbox[getb(s, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (inv) o[127-8*(r+4*((c+r)%4)) -: 8] = getb(s, r + 4*c);
        else     o[127-8*(r+4*c) -: 8]         = getb(s, r + 4*((c+r)%4));
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   v;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = getb(s, 4*c + r);
      for (int r = 0; r < 4; r++) begin
        v = 8'h00;
        for (int j = 0; j < 4; j++) v = v ^ gmul(m[j], a[(r+j)%4]);
        o[127-8*(4*c+r) -: 8] = v;
      end
    end
    return o;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [4*(NR+1)];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rk[0];
    for (int r = 1; r < NR; r++) s = mix_columns(shift_rows(sub_bytes(s, 0), 0), 0) ^ rk[r];
    return shift_rows(sub_bytes(s, 0), 0) ^ rk[NR];
  endfunction

  function automatic logic [127:0] stage_model(input logic [3:0] g, input logic [127:0] s,
                                               input logic [3:0] round);
    case (g)
      G_ADD:   return s ^ rk[round];
      G_SUB:   return sub_bytes(s, 1);
      G_SHIFT: return shift_rows(s, 1);
      default: return mix_columns(s, 1);
    endcase
  endfunction

  // ---------------- stage responder and Go monitor ----------------
  int rsp_max_dly = 1;
  bit rsp_junk    = 1'b0;
  bit rsp_never   = 1'b0;
  int dly_sum     = 0;
  int multi_go    = 0;
  int go_outside  = 0;
  logic [7:0] go_q [$];

  initial begin
    logic [127:0] res;
    int d;
    Ry   = 1'b0;
    Text = 128'd0;
    forever begin
      @(posedge clk); #1;
      Ry = 1'b0;
      if (!rst && go != 4'd0 && !rsp_never) begin
        res = stage_model(go, StageText, RoundIdx);
        d   = int'($urandom_range(rsp_max_dly, 1));
        dly_sum += d;
        if (rsp_junk) begin
          Ry   = 1'b1;
          Text = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        for (int i = 0; i < d; i++) begin
          @(posedge clk); #1;
          Ry   = (i == d - 1);
          Text = (i == d - 1) ? res : {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if ($countones(go) > 1) multi_go++;
      if (go != 4'd0 && !Busy) go_outside++;
      if ($countones(go) == 1) go_q.push_back({go, RoundIdx});
    end
  end

  // ---------------- test sequences ----------------
  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           max_dly;
    bit           junk;
    string        name;
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] g;
    logic [3:0] round;
  } tr_t;

  task automatic check_reset_outputs(input string tag);
    check({tag, " Busy"},      128'(Busy),      128'd0);
    check({tag, " Done"},      128'(Done),      128'd0);
    check({tag, " Error"},     128'(Error),     128'd0);
    check({tag, " PlainText"}, PlainText,       128'd0);
    check({tag, " StageText"}, StageText,       128'd0);
    check({tag, " RoundIdx"},  128'(RoundIdx),  128'd0);
    check({tag, " Go"},        128'(go),        128'd0);
  endtask

  task automatic run_op(input logic [127:0] ct, input logic [127:0] exp, input string name,
                        input int inject_go, output int lat);
    bit seen, injected;
    int busy_gaps;
    seen = 1'b0; injected = 1'b0; busy_gaps = 0; lat = 0;
    CipherText = ct;
    Start      = 1'b1;
    while (!seen && lat < 3000) begin
      @(posedge clk); lat++; #1;
      Start = 1'b0;
      if (lat == 1) begin
        check({name, " busy_on_accept"}, 128'(Busy), 128'd1);
        check({name, " error_clear"},    128'(Error), 128'd0);
      end
      if (inject_go > 0 && !injected && go_q.size() == inject_go) begin
        Start      = 1'b1;
        CipherText = ~ct;
        injected   = 1'b1;
      end
      if (Done) seen = 1'b1;
      else if (!Busy) busy_gaps++;
    end
    check({name, " done_seen"}, 128'(seen), 128'd1);
    if (inject_go > 0) check({name, " start_injected"}, 128'(injected), 128'd1);
    check({name, " plaintext"}, PlainText, exp);
    check({name, " busy_gaps"}, 128'(busy_gaps), 128'd0);
    @(posedge clk); #1;
    check({name, " done_pulse"},     128'(Done), 128'd0);
    check({name, " plaintext_held"}, PlainText, exp);
  endtask

  initial begin
    vec_t       vecs [NVEC];
    tr_t        trace_tab [7];
    logic [7:0] exp_trace [$];
    logic [127:0] pt;
    logic [7:0] got8;
    int lat, cyc, guard;
    bit got_err;

    rst = 1'b1; Start = 1'b0; CipherText = 128'd0;
    build_sbox();
    expand_key(KEY);

    vecs[0].ct = C1_CT; vecs[0].pt = C1_PT; vecs[0].max_dly = 1;  vecs[0].junk = 1'b0; vecs[0].name = "c1_fixed";
    vecs[1].ct = C1_CT; vecs[1].pt = C1_PT; vecs[1].max_dly = 20; vecs[1].junk = 1'b1; vecs[1].name = "c1_rand_dly";
    for (int i = 2; i < NVEC; i++) begin
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      vecs[i].ct = encrypt(pt); vecs[i].pt = pt;
      vecs[i].max_dly = (i % 2 == 0) ? 1 : 20;
      vecs[i].junk = (i % 2 == 1);
      vecs[i].name = $sformatf("rand%0d", i);
    end

    trace_tab[0] = '{0,  G_ADD,   4'd10};
    trace_tab[1] = '{1,  G_SHIFT, 4'd9};
    trace_tab[2] = '{2,  G_SUB,   4'd9};
    trace_tab[3] = '{3,  G_ADD,   4'd9};
    trace_tab[4] = '{37, G_SHIFT, 4'd0};
    trace_tab[5] = '{38, G_SUB,   4'd0};
    trace_tab[6] = '{39, G_ADD,   4'd0};

    exp_trace.push_back({G_ADD, 4'(NR)});
    for (int r = NR - 1; r >= 1; r--) begin
      exp_trace.push_back({G_SHIFT, 4'(r)});
      exp_trace.push_back({G_SUB,   4'(r)});
      exp_trace.push_back({G_ADD,   4'(r)});
      exp_trace.push_back({G_MIX,   4'(r)});
    end
    exp_trace.push_back({G_SHIFT, 4'd0});
    exp_trace.push_back({G_SUB,   4'd0});
    exp_trace.push_back({G_ADD,   4'd0});

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      rsp_max_dly = vecs[i].max_dly;
      rsp_junk    = vecs[i].junk;
      go_q.delete();
      dly_sum = 0; multi_go = 0; go_outside = 0;
      run_op(vecs[i].ct, vecs[i].pt, vecs[i].name, 0, lat);
      check({vecs[i].name, " latency"},    128'(lat), 128'(2 + 4*NR + dly_sum));
      check({vecs[i].name, " go_count"},   128'(go_q.size()), 128'(4*NR));
      check({vecs[i].name, " multi_go"},   128'(multi_go), 128'd0);
      check({vecs[i].name, " go_outside"}, 128'(go_outside), 128'd0);
      if (i == 0) begin
        check("c1 latency_82", 128'(lat), 128'(2 + 8*NR));
        for (int t = 0; t < 7; t++) begin
          got8 = (trace_tab[t].idx < go_q.size()) ? go_q[trace_tab[t].idx] : 8'hff;
          check($sformatf("trace_tab[%0d]", trace_tab[t].idx), 128'(got8),
                128'({trace_tab[t].g, trace_tab[t].round}));
        end
        for (int t = 0; t < 4*NR; t++) begin
          got8 = (t < go_q.size()) ? go_q[t] : 8'hff;
          check($sformatf("trace[%0d]", t), 128'(got8), 128'(exp_trace[t]));
        end
      end
    end

    // Stage that never answers: timeout, then recovery on the next Start.
    rsp_never = 1'b1; rsp_junk = 1'b0; rsp_max_dly = 1;
    CipherText = C1_CT; Start = 1'b1; cyc = 0; got_err = 1'b0;
    while (!got_err && cyc < TIMEOUT + 50) begin
      @(posedge clk); cyc++; #1;
      Start = 1'b0;
      if (Error) got_err = 1'b1;
    end
    check("timeout error_seen", 128'(got_err), 128'd1);
    check("timeout latency",    128'(cyc), 128'(TIMEOUT + 3));
    check("timeout busy",       128'(Busy), 128'd0);
    check("timeout done",       128'(Done), 128'd0);
    repeat (5) @(posedge clk);
    #1;
    check("timeout error_held", 128'(Error), 128'd1);
    rsp_never = 1'b0;
    run_op(C1_CT, C1_PT, "after_error", 0, lat);

    // New Start in the middle of an operation must be ignored.
    go_q.delete();
    run_op(C1_CT, C1_PT, "start_ignored", 15, lat);
    check("start_ignored go_count", 128'(go_q.size()), 128'(4*NR));

    // Reset mid-operation.
    go_q.delete();
    CipherText = C1_CT; Start = 1'b1; guard = 0;
    while (go_q.size() < 20 && guard < 500) begin
      @(posedge clk); guard++; #1;
      Start = 1'b0;
    end
    check("midrst reached_step20", 128'(go_q.size() >= 20), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst idle_busy", 128'(Busy), 128'd0);
    check("midrst idle_go",   128'(go), 128'd0);
    run_op(C1_CT, C1_PT, "after_rst", 0, lat);
    check("after_rst latency", 128'(lat), 128'(2 + 8*NR));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
